// File: rtl/id_stage_hz.sv
// Decode stage: register file with WB bypass, control decode, hazard detection,
// early branch/jump resolution and the registered ID/EX boundary.
module id_stage_hz #(
  parameter int NB_DATA = 32,
  parameter int NB_PC   = 32,
  parameter int NB_INST = 32,
  parameter int NB_REG  = 5,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clock,
  input  logic               i_ID_reset_n,
  input  logic               i_ID_enable,
  input  logic               i_ID_flush,
  input  logic [NB_INST-1:0] i_ID_inst,
  input  logic [NB_PC-1:0]   i_ID_pc,
  input  logic               i_ID_wb_reg_write,
  input  logic [NB_REG-1:0]  i_ID_wb_reg,
  input  logic [NB_DATA-1:0] i_ID_wb_data,
  input  logic               i_ID_ex_mem_read,
  input  logic               i_ID_ex_reg_write,
  input  logic [NB_REG-1:0]  i_ID_ex_dest,
  output logic               o_ID_stall,
  output logic               o_ID_redirect,
  output logic [NB_PC-1:0]   o_ID_redirect_pc,
  output logic               o_ID_reg_dest,
  output logic               o_ID_alu_src,
  output logic               o_ID_mem_read,
  output logic               o_ID_mem_write,
  output logic               o_ID_mem_to_reg,
  output logic               o_ID_reg_write,
  output logic               o_ID_link,
  output logic [5:0]         o_ID_alu_op,
  output logic [5:0]         o_ID_funct,
  output logic [NB_DATA-1:0] o_ID_data_a,
  output logic [NB_DATA-1:0] o_ID_data_b,
  output logic [NB_DATA-1:0] o_ID_immediate,
  output logic [NB_REG-1:0]  o_ID_rs,
  output logic [NB_REG-1:0]  o_ID_rt,
  output logic [NB_REG-1:0]  o_ID_rd,
  output logic [NB_PC-1:0]   o_ID_pc,
  output logic [NB_CNT-1:0]  o_ID_stall_count
);

  localparam int unsigned N_REGS = 2**NB_REG;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef struct packed {
    logic               reg_dest;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
    logic               link;
    logic [5:0]         alu_op;
    logic [5:0]         funct;
    logic [NB_DATA-1:0] data_a;
    logic [NB_DATA-1:0] data_b;
    logic [NB_DATA-1:0] imm;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  rd;
    logic [NB_PC-1:0]   pc;
  } idex_t;

  opcode_e             opcode;
  logic [5:0]          funct;
  logic [NB_REG-1:0]   rs, rt, rd;
  logic [15:0]         imm16;
  logic [NB_DATA-1:0]  regs [N_REGS];
  logic [NB_DATA-1:0]  data_a, data_b;
  logic                is_rtype, is_jr, is_jalr, is_beq, is_bne, is_j, is_jal;
  logic                uses_rt, is_branch, is_jreg;
  logic                load_use, branch_hz, taken;
  logic [NB_PC-1:0]    branch_target, jump_target;
  idex_t               dec, idex_q;
  logic [NB_CNT-1:0]   stall_cnt_q;

  assign opcode = opcode_e'(i_ID_inst[31:26]);
  assign funct  = i_ID_inst[5:0];
  assign rs     = NB_REG'(i_ID_inst[25:21]);
  assign rt     = NB_REG'(i_ID_inst[20:16]);
  assign rd     = NB_REG'(i_ID_inst[15:11]);
  assign imm16  = i_ID_inst[15:0];

  always_ff @(posedge i_clock) begin
    if (!i_ID_reset_n) begin
      for (int unsigned i = 0; i < N_REGS; i++) regs[NB_REG'(i)] <= '0;
    end else if (i_ID_wb_reg_write && i_ID_wb_reg != '0) begin
      regs[i_ID_wb_reg] <= i_ID_wb_data;
    end
  end

  // Same-cycle WB bypass so a value written this edge is visible to decode now.
  assign data_a = (rs == '0) ? '0 :
                  (i_ID_wb_reg_write && i_ID_wb_reg == rs) ? i_ID_wb_data : regs[rs];
  assign data_b = (rt == '0) ? '0 :
                  (i_ID_wb_reg_write && i_ID_wb_reg == rt) ? i_ID_wb_data : regs[rt];

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_jr     = is_rtype && (funct == 6'b001000);
  assign is_jalr   = is_rtype && (funct == 6'b001001);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = (opcode == OP_BNE);
  assign is_j      = (opcode == OP_J);
  assign is_jal    = (opcode == OP_JAL);
  assign is_branch = is_beq || is_bne;
  assign is_jreg   = is_jr || is_jalr;
  assign uses_rt   = is_rtype || (opcode == OP_SW) || is_branch;

  always_comb begin
    dec        = '0;
    dec.alu_op = i_ID_inst[31:26];
    dec.funct  = funct;
    dec.data_a = data_a;
    dec.data_b = data_b;
    dec.imm    = {{(NB_DATA-16){imm16[15]}}, imm16};
    dec.rs     = rs;
    dec.rt     = rt;
    dec.rd     = rd;
    dec.pc     = i_ID_pc;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dest  = 1'b1;
        dec.reg_write = !is_jr;
        dec.link      = is_jalr;
      end
      OP_LW: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_JAL: begin
        dec.link      = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use  = i_ID_ex_mem_read && (i_ID_ex_dest != '0) &&
                     ((i_ID_ex_dest == rs) || (uses_rt && i_ID_ex_dest == rt));
  assign branch_hz = (is_branch || is_jreg) && i_ID_ex_reg_write && (i_ID_ex_dest != '0) &&
                     ((i_ID_ex_dest == rs) || (is_branch && i_ID_ex_dest == rt));
  assign o_ID_stall = (load_use || branch_hz) && i_ID_enable;

  assign branch_target = i_ID_pc + {{(NB_PC-16){imm16[15]}}, imm16};
  assign jump_target   = {i_ID_pc[NB_PC-1:26], i_ID_inst[25:0]};

  assign taken = (is_beq && data_a == data_b) || (is_bne && data_a != data_b) ||
                 is_j || is_jal || is_jreg;
  assign o_ID_redirect = taken && i_ID_enable && !o_ID_stall && !i_ID_flush;

  always_comb begin
    o_ID_redirect_pc = branch_target;
    if (is_jreg)           o_ID_redirect_pc = NB_PC'(data_a);
    else if (is_j || is_jal) o_ID_redirect_pc = jump_target;
  end

  always_ff @(posedge i_clock) begin
    if (!i_ID_reset_n) begin
      idex_q <= '0;
    end else if (i_ID_enable) begin
      if (i_ID_flush || o_ID_stall) idex_q <= '0;
      else                          idex_q <= dec;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_ID_reset_n)                          stall_cnt_q <= '0;
    else if (o_ID_stall && stall_cnt_q != '1)   stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign o_ID_reg_dest    = idex_q.reg_dest;
  assign o_ID_alu_src     = idex_q.alu_src;
  assign o_ID_mem_read    = idex_q.mem_read;
  assign o_ID_mem_write   = idex_q.mem_write;
  assign o_ID_mem_to_reg  = idex_q.mem_to_reg;
  assign o_ID_reg_write   = idex_q.reg_write;
  assign o_ID_link        = idex_q.link;
  assign o_ID_alu_op      = idex_q.alu_op;
  assign o_ID_funct       = idex_q.funct;
  assign o_ID_data_a      = idex_q.data_a;
  assign o_ID_data_b      = idex_q.data_b;
  assign o_ID_immediate   = idex_q.imm;
  assign o_ID_rs          = idex_q.rs;
  assign o_ID_rt          = idex_q.rt;
  assign o_ID_rd          = idex_q.rd;
  assign o_ID_pc          = idex_q.pc;
  assign o_ID_stall_count = stall_cnt_q;

endmodule
